// File: rtl/ysyx_25070198_mem_arbiter_if.sv
// Shared memory-port bundle between IFU/LSU requesters, the arbiter and memory.
// The arbiter takes the slave view; the environment driving it takes master.
interface ysyx_25070198_mem_arbiter_if;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [29:0] ifu_req_addr;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rsp_data;

   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [29:0] lsu_req_addr;
   logic        lsu_req_wen;
   logic [31:0] lsu_req_wdata;
   logic [3:0]  lsu_req_mask;
   logic        lsu_rsp_valid;
   logic [31:0] lsu_rsp_data;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [29:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mask;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;

   modport slave (
      input  ifu_req_valid, ifu_req_addr,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
      input  lsu_req_valid, lsu_req_addr, lsu_req_wen,
      input  lsu_req_wdata, lsu_req_mask,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_mask,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data
   );

   modport master (
      output ifu_req_valid, ifu_req_addr,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
      output lsu_req_valid, lsu_req_addr, lsu_req_wen,
      output lsu_req_wdata, lsu_req_mask,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_mask,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data
   );
endinterface

// File: rtl/ysyx_25070198_mem_arbiter.sv
// IFU/LSU arbiter for the single memory port: one transaction in flight,
// registered request toward memory, response routed back to its owner.
module ysyx_25070198_mem_arbiter #(
   parameter bit PRIO_LSU = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst,
   ysyx_25070198_mem_arbiter_if.slave        bus,
   output logic                              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_last_lsu;
   logic        r_owner_lsu;
   logic        r_mem_req_valid;
   logic [29:0] r_mem_addr;
   logic        r_mem_wen;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_mask;
   logic        r_ifu_rsp_valid;
   logic [31:0] r_ifu_rsp_data;
   logic        r_lsu_rsp_valid;
   logic [31:0] r_lsu_rsp_data;

   logic        w_idle;
   logic        w_conflict;
   logic        w_grant_lsu;
   logic        w_grant_ifu;

   assign w_idle     = (r_state == S_IDLE);
   assign w_conflict = bus.ifu_req_valid && bus.lsu_req_valid;

   // On a conflict LSU wins under fixed priority, or when IFU got the last grant.
   assign w_grant_lsu = w_idle && bus.lsu_req_valid &&
                        (!w_conflict || PRIO_LSU || !r_last_lsu);
   assign w_grant_ifu = w_idle && bus.ifu_req_valid && !w_grant_lsu;

   assign bus.ifu_req_ready = w_grant_ifu;
   assign bus.lsu_req_ready = w_grant_lsu;

   assign bus.mem_req_valid = r_mem_req_valid;
   assign bus.mem_addr      = r_mem_addr;
   assign bus.mem_wen       = r_mem_wen;
   assign bus.mem_wdata     = r_mem_wdata;
   assign bus.mem_mask      = r_mem_mask;

   assign bus.ifu_rsp_valid = r_ifu_rsp_valid;
   assign bus.ifu_rsp_data  = r_ifu_rsp_data;
   assign bus.lsu_rsp_valid = r_lsu_rsp_valid;
   assign bus.lsu_rsp_data  = r_lsu_rsp_data;

   assign busy = (r_state != S_IDLE);

   // Transaction FSM: latch the granted request, present it, route the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_last_lsu      <= 1'b1;
         r_owner_lsu     <= 1'b0;
         r_mem_req_valid <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_wen       <= 1'b0;
         r_mem_wdata     <= '0;
         r_mem_mask      <= '0;
         r_ifu_rsp_valid <= 1'b0;
         r_ifu_rsp_data  <= '0;
         r_lsu_rsp_valid <= 1'b0;
         r_lsu_rsp_data  <= '0;
      end else begin
         r_ifu_rsp_valid <= 1'b0;
         r_lsu_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_lsu) begin
                  r_state         <= S_REQ;
                  r_last_lsu      <= 1'b1;
                  r_owner_lsu     <= 1'b1;
                  r_mem_req_valid <= 1'b1;
                  r_mem_addr      <= bus.lsu_req_addr;
                  r_mem_wen       <= bus.lsu_req_wen;
                  r_mem_wdata     <= bus.lsu_req_wdata;
                  r_mem_mask      <= bus.lsu_req_mask;
               end else if (w_grant_ifu) begin
                  r_state         <= S_REQ;
                  r_last_lsu      <= 1'b0;
                  r_owner_lsu     <= 1'b0;
                  r_mem_req_valid <= 1'b1;
                  r_mem_addr      <= bus.ifu_req_addr;
                  r_mem_wen       <= 1'b0;
                  r_mem_wdata     <= '0;
                  r_mem_mask      <= 4'b1111;
               end
            end
            S_REQ: begin
               if (bus.mem_req_ready) begin
                  r_state         <= S_WAIT;
                  r_mem_req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (bus.mem_rsp_valid) begin
                  r_state <= S_IDLE;
                  if (r_owner_lsu) begin
                     r_lsu_rsp_valid <= 1'b1;
                     r_lsu_rsp_data  <= bus.mem_rsp_data;
                  end else begin
                     r_ifu_rsp_valid <= 1'b1;
                     r_ifu_rsp_data  <= bus.mem_rsp_data;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter, with a small memory model
// and a response monitor that checks routing against the grant order.
module tb_ysyx_25070198_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic busy2;

   always #5 clk = ~clk;

   ysyx_25070198_mem_arbiter_if bus ();
   ysyx_25070198_mem_arbiter_if bus2 ();

   ysyx_25070198_mem_arbiter #(.PRIO_LSU(1'b0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .busy(busy)
   );

   ysyx_25070198_mem_arbiter #(.PRIO_LSU(1'b1)) u_dut_prio (
      .clk (clk),
      .rst (rst),
      .bus (bus2),
      .busy(busy2)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [95:0] act,
                      input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] mdata(input logic [29:0] a);
      return (a == 30'h2000_0000) ? 32'h0000_0413 : {2'b10, a};
   endfunction

   // memory model for the round-robin instance
   int          g_stall;
   int          g_lat;
   int          stall_cnt;
   int          rsp_cnt;
   logic [29:0] acc_addr;
   logic        acc_wen;

   initial begin
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      stall_cnt = 0;
      rsp_cnt   = 0;
      acc_addr  = '0;
      acc_wen   = 1'b0;
      forever begin
         @(negedge clk);
         bus.mem_rsp_valid = 1'b0;
         if (bus.mem_req_ready) begin
            acc_addr = bus.mem_addr;
            acc_wen  = bus.mem_wen;
            rsp_cnt  = g_lat;
            stall_cnt = 0;
            bus.mem_req_ready = 1'b0;
         end else if (bus.mem_req_valid) begin
            if (stall_cnt >= g_stall) bus.mem_req_ready = 1'b1;
            else stall_cnt++;
         end
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               bus.mem_rsp_valid = 1'b1;
               bus.mem_rsp_data  = mdata(acc_addr);
            end
         end
      end
   end

   // requesters and memory for the LSU-priority instance: both always valid
   int   n2_ifu = 0;
   int   n2_lsu = 0;
   logic p2;

   initial begin
      bus2.ifu_req_valid = 1'b1;
      bus2.ifu_req_addr  = 30'h5;
      bus2.lsu_req_valid = 1'b1;
      bus2.lsu_req_addr  = 30'h6;
      bus2.lsu_req_wen   = 1'b0;
      bus2.lsu_req_wdata = '0;
      bus2.lsu_req_mask  = 4'hf;
      bus2.mem_req_ready = 1'b1;
      bus2.mem_rsp_valid = 1'b0;
      bus2.mem_rsp_data  = '0;
      p2 = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus2.ifu_rsp_valid) n2_ifu++;
            if (bus2.lsu_rsp_valid) n2_lsu++;
         end
         bus2.mem_rsp_valid = p2 && !rst;
         if (p2) bus2.mem_rsp_data = {2'b10, bus2.mem_addr};
         p2 = bus2.mem_req_valid && !rst;
      end
   end

   // response monitor: each rsp must go to the oldest outstanding grant
   bit          q_own[$];
   logic [32:0] q_dat[$];
   bit          glog[$];
   int          n_ifu_rsp = 0;
   int          n_lsu_rsp = 0;

   task automatic rsp_seen(input bit own, input logic [31:0] d);
      if (q_own.size() == 0) begin
         chk("rsp_orphan", 1, 0);
      end else begin
         chk("rsp_owner", q_own[0], own);
         if (!q_dat[0][32]) chk("rsp_data", d, q_dat[0][31:0]);
         void'(q_own.pop_front());
         void'(q_dat.pop_front());
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            q_own.delete();
            q_dat.delete();
         end else begin
            chk("one_ready", bus.ifu_req_ready & bus.lsu_req_ready, 0);
            if (bus.ifu_rsp_valid) begin
               n_ifu_rsp++;
               rsp_seen(1'b0, bus.ifu_rsp_data);
            end
            if (bus.lsu_rsp_valid) begin
               n_lsu_rsp++;
               rsp_seen(1'b1, bus.lsu_rsp_data);
            end
            if (bus.ifu_req_ready && bus.ifu_req_valid) begin
               q_own.push_back(1'b0);
               q_dat.push_back({1'b0, mdata(bus.ifu_req_addr)});
               glog.push_back(1'b0);
            end
            if (bus.lsu_req_ready && bus.lsu_req_valid) begin
               q_own.push_back(1'b1);
               q_dat.push_back({bus.lsu_req_wen, mdata(bus.lsu_req_addr)});
               glog.push_back(1'b1);
            end
         end
      end
   end

   int         c0;
   int         c1;
   logic [3:0] gv;

   initial begin
      rst = 1'b1;
      g_stall = 0;
      g_lat   = 1;
      bus.ifu_req_valid = 1'b0;
      bus.ifu_req_addr  = '0;
      bus.lsu_req_valid = 1'b0;
      bus.lsu_req_addr  = '0;
      bus.lsu_req_wen   = 1'b0;
      bus.lsu_req_wdata = '0;
      bus.lsu_req_mask  = '0;
      tick(3);
      #1;
      chk("rst_mem", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen,
                      bus.mem_wdata, bus.mem_mask}, 0);
      chk("rst_rsp", {bus.ifu_rsp_valid, bus.ifu_rsp_data,
                      bus.lsu_rsp_valid, bus.lsu_rsp_data, busy}, 0);
      @(negedge clk);
      rst = 1'b0;
      tick(1);

      // IFU read alone
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 30'h2000_0000;
      #1 chk("t1_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
      tick(1);
      bus.ifu_req_valid = 1'b0;
      bus.ifu_req_addr  = '0;
      #1 chk("t1_req", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen,
                        bus.mem_wdata, bus.mem_mask},
                       {1'b1, 30'h2000_0000, 1'b0, 32'h0, 4'hf});
      tick(1);
      #1 chk("t1_wait", {bus.mem_req_valid, busy, bus.ifu_rsp_valid}, 3'b010);
      tick(1);
      #1 chk("t1_rsp", {bus.ifu_rsp_valid, bus.ifu_rsp_data,
                        bus.lsu_rsp_valid}, {1'b1, 32'h0000_0413, 1'b0});
      tick(1);
      #1 chk("t1_after", {bus.ifu_rsp_valid, bus.ifu_rsp_data, busy},
                         {1'b0, 32'h0000_0413, 1'b0});
      chk("t1_no_lsu", n_lsu_rsp, 0);

      // LSU store alone
      tick(1);
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 30'h2000_0100;
      bus.lsu_req_wen   = 1'b1;
      bus.lsu_req_wdata = 32'h00AB_0000;
      bus.lsu_req_mask  = 4'b0100;
      #1 chk("t2_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b01);
      tick(1);
      bus.lsu_req_valid = 1'b0;
      #1 chk("t2_req", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen,
                        bus.mem_wdata, bus.mem_mask},
                       {1'b1, 30'h2000_0100, 1'b1, 32'h00AB_0000, 4'b0100});
      tick(2);
      #1 chk("t2_rsp", {bus.lsu_rsp_valid, bus.ifu_rsp_valid,
                        bus.ifu_rsp_data}, {1'b1, 1'b0, 32'h0000_0413});
      chk("t2_mem_wen", acc_wen, 1'b1);
      tick(1);
      #1 chk("t2_pulse", {bus.lsu_rsp_valid, n_lsu_rsp}, {1'b0, 32'd1});

      // both requesters continuously valid, round-robin
      tick(1);
      glog.delete();
      c0 = n_ifu_rsp;
      c1 = n_lsu_rsp;
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 30'h100;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 30'h200;
      bus.lsu_req_wen   = 1'b0;
      bus.lsu_req_wdata = '0;
      bus.lsu_req_mask  = 4'hf;
      tick(12);
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      tick(4);
      gv = '0;
      for (int i = 0; i < 4; i++)
         if (i < glog.size()) gv[i] = glog[i];
      chk("t3_order", {glog.size(), gv}, {32'd4, 4'b1010});
      chk("t3_counts", {n_ifu_rsp - c0, n_lsu_rsp - c1}, {32'd2, 32'd2});

      // memory stalls 4 cycles, responds 5 cycles after accept
      tick(1);
      g_stall = 4;
      g_lat   = 5;
      c0 = n_ifu_rsp;
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 30'h40;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 30'h300;
      #1 chk("t4_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (i == 0) bus.ifu_req_valid = 1'b0;
         #1 chk("t4_stall", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen,
                             bus.mem_mask, busy, bus.ifu_req_ready,
                             bus.lsu_req_ready},
                            {1'b1, 30'h40, 1'b0, 4'hf, 1'b1, 2'b00});
      end
      for (int i = 0; i < 5; i++) begin
         tick(1);
         #1 chk("t4_wait", {bus.mem_req_valid, busy, bus.ifu_req_ready,
                            bus.lsu_req_ready, bus.ifu_rsp_valid}, 5'b01000);
         if (i == 4) bus.lsu_req_valid = 1'b0;
      end
      tick(1);
      #1 chk("t4_rsp", {bus.ifu_rsp_valid, bus.ifu_rsp_data,
                        bus.lsu_rsp_valid}, {1'b1, 2'b10, 30'h40, 1'b0});
      tick(1);
      #1 chk("t4_pulse", {bus.ifu_rsp_valid, n_ifu_rsp - c0}, {1'b0, 32'd1});
      g_stall = 0;

      // reset during WAIT, stray response afterwards
      tick(1);
      g_lat = 4;
      c0 = n_ifu_rsp;
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 30'h80;
      #1 chk("t5_ready", bus.ifu_req_ready, 1'b1);
      tick(1);
      bus.ifu_req_valid = 1'b0;
      tick(1);
      #1 chk("t5_in_wait", {bus.mem_req_valid, busy}, 2'b01);
      rst = 1'b1;
      #1 chk("t5_rst_mem", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen,
                            bus.mem_wdata, bus.mem_mask, busy}, 0);
      chk("t5_rst_rsp", {bus.ifu_rsp_valid, bus.ifu_rsp_data,
                         bus.lsu_rsp_valid, bus.lsu_rsp_data}, 0);
      tick(1);
      rst = 1'b0;
      tick(2);
      #1 chk("t5_stray", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, busy}, 0);
      tick(1);
      #1 chk("t5_stray2", {bus.ifu_rsp_valid, n_ifu_rsp - c0}, 0);
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 30'h2000_0000;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 30'h10;
      bus.lsu_req_wen   = 1'b0;
      g_lat = 1;
      #1 chk("t5_first_rr", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
      tick(1);
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      tick(2);
      #1 chk("t5_next", {bus.ifu_rsp_valid, bus.ifu_rsp_data,
                         bus.lsu_rsp_valid}, {1'b1, 32'h0000_0413, 1'b0});

      tick(3);
      chk("q_drained", q_own.size(), 0);
      chk("p1_ifu_rsp", n2_ifu, 0);
      chk("p1_lsu_rsp", n2_lsu >= 10, 1'b1);
      chk("p1_lsu_data", bus2.lsu_rsp_data, {2'b10, 30'h6});

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
